disp_pixel_buffer: RTL and testbench
====================================

Name: disp_pixel_buffer

Overview:
- Frame-synchronised pixel buffer sitting directly upstream of the display timing driver.
- Accepts pixels from the SDRAM read port into an internal first-word-fall-through FIFO.
- Presents the head pixel combinationally on Data so the driver can latch it in the same cycle it asserts DataReq.
- Flushes and re-primes at every vertical sync, requests a new frame from the SDRAM reader, and flags underflow.

Parameters:
- DATA_W, 16, pixel width (must equal sum of Red/Green/Blue bits in the display config).
- DEPTH_LOG2, 9, FIFO depth = 2**DEPTH_LOG2 entries.
- PREFILL, 256, FIFO level that must be reached before streaming is enabled; valid range 1..2**DEPTH_LOG2.
- AFULL_MARGIN, 8, Wr_Ready deasserts when free entries <= this value.
- FILL_COLOR, 16'h0000, pixel driven on Data when no valid pixel is available.

Ports:
- ClkDisp  in  1  display pixel clock; all logic on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Disp_VS  in  1  vertical sync from the display driver (active-low sync pulse).
- Wr_Data  in  DATA_W  pixel from SDRAM read port.
- Wr_En  in  1  write strobe; ignored when FIFO is full.
- Wr_Ready  out  1  space available (free > AFULL_MARGIN).
- Frame_Start  out  1  one-cycle pulse telling the SDRAM reader to restart at frame base address.
- DataReq  in  1  pixel consume strobe from the display driver.
- Data  out  DATA_W  head pixel or FILL_COLOR.
- Streaming  out  1  high in STREAM state.
- Underflow  out  1  sticky per frame; set on DataReq in STREAM with FIFO empty.
- Level  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (Rst high, async): state IDLE, pointers 0, Level 0, Wr_Ready 0, Frame_Start 0, Underflow 0, Streaming 0. Data = FILL_COLOR.
- VS edge detect: register Disp_VS once; frame event = falling edge (previous 1, current 0). Before the first registered sample after reset, the previous-value register is 1.
- States: IDLE, FLUSH, PREFILL, STREAM.
  - Any state, on frame event: go to FLUSH. This includes mid-frame in STREAM.
  - FLUSH (exactly 1 cycle): pointers and Level cleared, Underflow cleared, Frame_Start=1, Wr_En ignored, Wr_Ready=0. Next state is PREFILL.
  - PREFILL: Wr_Ready per margin rule; writes accepted. When Level >= PREFILL (registered compare), go to STREAM next cycle.
  - STREAM: Streaming=1; DataReq with non-empty FIFO pops one entry.
- Data is combinational from mem[rd_ptr] when state==STREAM and FIFO is non-empty; otherwise FILL_COLOR. Pop takes effect at the clock edge, so zero-latency head presentation.
- DataReq outside STREAM: no pop, Data=FILL_COLOR, Underflow unchanged.
- Underflow: DataReq && STREAM && empty sets Underflow at the next edge; holds until the next FLUSH.
- Simultaneous write and pop: Level unchanged. Write to an empty FIFO becomes visible on Data the following cycle.
- Write when full: dropped, no pointer change. Full when Level == 2**DEPTH_LOG2.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Level is tracked separately with DEPTH_LOG2+1 bits.
- Memory: inferred dual-port with asynchronous read (distributed RAM acceptable at the default depth).

Optional Feature:
- Macro DISP_BUF_UFCNT_EN.
- When defined: adds output Underflow_Cnt [15:0].
  - Counts DataReq-on-empty events in STREAM.
  - Saturates at 16'hFFFF.
  - Cleared by reset only, not by FLUSH.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-stream: assert Rst while in STREAM with Level=100 -> same cycle Level=0, Streaming=0, Data=16'h0000, Wr_Ready=0.
- Frame prime: falling edge on Disp_VS -> Frame_Start high exactly 1 cycle. Write 256 pixels 0x0001..0x0100 -> Streaming rises 1-2 cycles after 256th write, and Data=0x0001.
- Stream order: in STREAM, assert DataReq 256 consecutive cycles while writing -> Data sequence 0x0001,0x0002,... with no gaps or repeats; Underflow stays 0.
- Underflow: stop writes, DataReq for Level+3 cycles -> last 3 cycles Data=FILL_COLOR and Underflow=1 thereafter. Next VS falling edge -> Underflow=0.
- Full / backpressure: DEPTH_LOG2=4, AFULL_MARGIN=2, write 20 without DataReq -> Wr_Ready=0 at Level 14, Level saturates at 16, writes 17-20 dropped.
- Mid-frame VS: VS falling edge in STREAM with Level=50 and DataReq held -> FLUSH, Level=0, Data=FILL_COLOR, no pop counted. With DISP_BUF_UFCNT_EN, Underflow_Cnt unchanged.

Source files
------------

// File: rtl/disp_pixel_buffer_if.sv
// Bus between the display pixel buffer and its SDRAM reader / timing driver.
// Underflow_Cnt exists only when DISP_BUF_UFCNT_EN is defined.
interface disp_pixel_buffer_if #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9
);
  logic              Disp_VS;
  logic [DATA_W-1:0] Wr_Data;
  logic              Wr_En;
  logic              Wr_Ready;
  logic              Frame_Start;
  logic              DataReq;
  logic [DATA_W-1:0] Data;
  logic              Streaming;
  logic              Underflow;
  logic [DEPTH_LOG2:0] Level;
`ifdef DISP_BUF_UFCNT_EN
  logic [15:0]       Underflow_Cnt;
`endif

  modport slave (
    input  Disp_VS, Wr_Data, Wr_En, DataReq,
`ifdef DISP_BUF_UFCNT_EN
    output Underflow_Cnt,
`endif
    output Wr_Ready, Frame_Start, Data, Streaming, Underflow, Level
  );

  modport master (
    output Disp_VS, Wr_Data, Wr_En, DataReq,
`ifdef DISP_BUF_UFCNT_EN
    input  Underflow_Cnt,
`endif
    input  Wr_Ready, Frame_Start, Data, Streaming, Underflow, Level
  );
endinterface

// File: rtl/disp_pixel_buffer.sv
// Frame-synchronised FWFT pixel FIFO feeding the display timing driver.
// Optional saturating underflow event counter: define DISP_BUF_UFCNT_EN.
module disp_pixel_buffer #(
  parameter int                DATA_W       = 16,
  parameter int                DEPTH_LOG2   = 9,
  parameter int                PREFILL      = 256,
  parameter int                AFULL_MARGIN = 8,
  parameter logic [DATA_W-1:0] FILL_COLOR   = 16'h0000
) (
  input  logic                ClkDisp,
  input  logic                Rst,
  disp_pixel_buffer_if.slave  bus
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(2**DEPTH_LOG2);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [LW-1:0] MARGIN_L  = LW'(AFULL_MARGIN);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_PREFILL = 2'd2;
  localparam logic [1:0] S_STREAM  = 2'd3;

  logic [1:0]            state;
  logic                  vs_q;
  logic                  pf_hit;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  underflow;
  logic [DATA_W-1:0]     mem [0:2**DEPTH_LOG2-1];

  logic frame_ev, flush, empty, full, accepting, wr_ok, rd_req, pop, uf_ev;

  // A frame event flushes on the very edge it is seen, so a mid-frame VS
  // never lets a pop or write slip through before FLUSH takes over.
  assign frame_ev  = vs_q & ~bus.Disp_VS;
  assign flush     = frame_ev | (state == S_FLUSH);
  assign empty     = (level == '0);
  assign full      = (level == DEPTH_L);
  assign accepting = (state == S_PREFILL) || (state == S_STREAM);
  assign wr_ok     = !flush && accepting && bus.Wr_En && !full;
  assign rd_req    = !flush && (state == S_STREAM) && bus.DataReq;
  assign pop       = rd_req && !empty;
  assign uf_ev     = rd_req && empty;

  always_ff @(posedge ClkDisp or posedge Rst) begin
    if (Rst) begin
      state  <= S_IDLE;
      vs_q   <= 1'b1;
      pf_hit <= 1'b0;
    end else begin
      vs_q   <= bus.Disp_VS;
      pf_hit <= !flush && (state == S_PREFILL) && (level >= PREFILL_L);
      if (frame_ev) state <= S_FLUSH;
      else begin
        case (state)
          S_FLUSH:   state <= S_PREFILL;
          S_PREFILL: if (pf_hit) state <= S_STREAM;
          default:   state <= state;
        endcase
      end
    end
  end

  always_ff @(posedge ClkDisp or posedge Rst) begin
    if (Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (uf_ev) underflow <= 1'b1;
    end
  end

  always_ff @(posedge ClkDisp) begin
    if (wr_ok) mem[wr_ptr] <= bus.Wr_Data;
  end

`ifdef DISP_BUF_UFCNT_EN
  logic [15:0] uf_cnt;
  always_ff @(posedge ClkDisp or posedge Rst) begin
    if (Rst)                              uf_cnt <= '0;
    else if (uf_ev && uf_cnt != 16'hFFFF) uf_cnt <= uf_cnt + 16'd1;
  end
  assign bus.Underflow_Cnt = uf_cnt;
`endif

  // Head pixel is presented combinationally so the driver latches it with DataReq.
  assign bus.Data        = (state == S_STREAM && !empty) ? mem[rd_ptr] : FILL_COLOR;
  assign bus.Wr_Ready    = accepting && !flush && ((DEPTH_L - level) > MARGIN_L);
  assign bus.Frame_Start = (state == S_FLUSH);
  assign bus.Streaming   = (state == S_STREAM);
  assign bus.Underflow   = underflow;
  assign bus.Level       = level;
endmodule

// File: tb/tb_disp_pixel_buffer.sv
// Scoreboarded bench: default-size buffer for framing/stream/underflow, 16-deep one for backpressure.
module tb_disp_pixel_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_pixel_buffer_if #(.DATA_W(16), .DEPTH_LOG2(9)) m();
  disp_pixel_buffer_if #(.DATA_W(16), .DEPTH_LOG2(4)) s();

  disp_pixel_buffer #(.DATA_W(16), .DEPTH_LOG2(9), .PREFILL(256), .AFULL_MARGIN(8),
                      .FILL_COLOR(16'h0000))
    u_m (.ClkDisp(clk), .Rst(rst), .bus(m.slave));

  disp_pixel_buffer #(.DATA_W(16), .DEPTH_LOG2(4), .PREFILL(16), .AFULL_MARGIN(2),
                      .FILL_COLOR(16'h0000))
    u_s (.ClkDisp(clk), .Rst(rst), .bus(s.slave));

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Pops one expected pixel per cycle the driver consumes on the main buffer.
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (m.DataReq === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL data_pop: got %0h with no expected pixel queued", m.Data);
        end else begin
          e = exp_q.pop_front();
          chk("data_pop", m.Data, e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [15:0] e);
    m.DataReq = 1'b1;
    exp_q.push_back(e);
    step();
    m.DataReq = 1'b0;
  endtask

  task automatic prime_m(input logic [15:0] base);
    int n;
    m.Disp_VS = 1'b0;
    step();
    chk("frame_start", m.Frame_Start, 1);
    chk("flush_wr_ready", m.Wr_Ready, 0);
    chk("flush_underflow", m.Underflow, 0);
    chk("flush_level", m.Level, 0);
    m.Disp_VS = 1'b1;
    step();
    chk("frame_start_1cyc", m.Frame_Start, 0);
    chk("prefill_wr_ready", m.Wr_Ready, 1);
    for (int i = 0; i < 256; i++) begin
      m.Wr_Data = base + 16'(i);
      m.Wr_En   = 1'b1;
      step();
    end
    m.Wr_En = 1'b0;
    n = 0;
    while (m.Streaming !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    chk("stream_latency_ok", (n >= 1 && n <= 2), 1);
    chk("head_pixel", m.Data, base);
    chk("prime_level", m.Level, 256);
  endtask

  initial begin
    m.Disp_VS = 1'b1; m.Wr_Data = '0; m.Wr_En = 1'b0; m.DataReq = 1'b0;
    s.Disp_VS = 1'b1; s.Wr_Data = '0; s.Wr_En = 1'b0; s.DataReq = 1'b0;
    fork monitor(); join_none

    // reset state
    #2;
    chk("rst_level", m.Level, 0);
    chk("rst_streaming", m.Streaming, 0);
    chk("rst_data", m.Data, 16'h0000);
    chk("rst_wr_ready", m.Wr_Ready, 0);
    chk("rst_frame_start", m.Frame_Start, 0);
    chk("rst_underflow", m.Underflow, 0);
    step(); step();
    rst = 1'b0;
    step();

    // frame prime with 0x0001..0x0100
    prime_m(16'h0001);

    // stream order: pop 256 while refilling with 0x0101..0x0200
    for (int k = 0; k < 256; k++) begin
      m.Wr_Data = 16'h0101 + 16'(k);
      m.Wr_En   = 1'b1;
      req(16'h0001 + 16'(k));
    end
    m.Wr_En = 1'b0;
    chk("stream_underflow", m.Underflow, 0);
    chk("stream_level", m.Level, 256);

    // underflow: drain then 3 requests on empty
    for (int k = 0; k < 256; k++) req(16'h0101 + 16'(k));
    for (int k = 0; k < 3; k++) req(16'h0000);
    chk("uf_set", m.Underflow, 1);
    chk("uf_level", m.Level, 0);
    step(); step();
    chk("uf_sticky", m.Underflow, 1);
    chk("uf_fill", m.Data, 16'h0000);
`ifdef DISP_BUF_UFCNT_EN
    chk("uf_cnt", m.Underflow_Cnt, 3);
`endif

    // next frame clears underflow (checked inside prime), then mid-frame VS at Level 50
    prime_m(16'h1000);
    for (int k = 0; k < 206; k++) req(16'h1000 + 16'(k));
    chk("mid_level50", m.Level, 50);
    m.DataReq = 1'b1;
    m.Disp_VS = 1'b0;
    exp_q.push_back(16'h1000 + 16'd206);
    step();
    chk("mid_flush_level", m.Level, 0);
    chk("mid_flush_streaming", m.Streaming, 0);
    chk("mid_flush_frame_start", m.Frame_Start, 1);
    exp_q.push_back(16'h0000);
    m.Disp_VS = 1'b1;
    step();
    exp_q.push_back(16'h0000);
    step();
    m.DataReq = 1'b0;
    chk("mid_no_underflow", m.Underflow, 0);
    chk("mid_level_after", m.Level, 0);
`ifdef DISP_BUF_UFCNT_EN
    chk("mid_uf_cnt", m.Underflow_Cnt, 3);
`endif

    // backpressure on the 16-deep buffer
    s.Disp_VS = 1'b0;
    step();
    s.Disp_VS = 1'b1;
    step();
    for (int i = 1; i <= 20; i++) begin
      s.Wr_Data = 16'(i);
      s.Wr_En   = 1'b1;
      step();
      if (i == 13) chk("bp_ready_at13", s.Wr_Ready, 1);
      if (i == 14) begin
        chk("bp_ready_at14", s.Wr_Ready, 0);
        chk("bp_level14", s.Level, 14);
      end
    end
    s.Wr_En = 1'b0;
    chk("bp_level_sat", s.Level, 16);
    chk("bp_streaming", s.Streaming, 1);
    chk("bp_head_not_overwritten", s.Data, 16'h0001);

    // async reset mid-stream at Level 100
    prime_m(16'h2000);
    for (int k = 0; k < 156; k++) req(16'h2000 + 16'(k));
    chk("pre_rst_level", m.Level, 100);
    rst = 1'b1;
    #1;
    chk("mid_rst_level", m.Level, 0);
    chk("mid_rst_streaming", m.Streaming, 0);
    chk("mid_rst_data", m.Data, 16'h0000);
    chk("mid_rst_wr_ready", m.Wr_Ready, 0);
    chk("mid_rst_s_level", s.Level, 0);
    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
